// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a shared pipelined multiplier, with credit-gated issue
// and per-requester in-order response FIFOs that resolve the carry-save result.

module mul_arbiter_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         empty,
  output logic         full,
  output logic         drop,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module mul_arbiter #(
  parameter int LAT    = 3,
  parameter int FDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s0_vld,
  output logic        s0_rdy,
  input  logic [15:0] s0_a,
  input  logic [15:0] s0_b,
  input  logic        s1_vld,
  output logic        s1_rdy,
  input  logic [15:0] s1_a,
  input  logic [15:0] s1_b,
  output logic        m_vld,
  output logic [15:0] m_a,
  output logic [15:0] m_b,
  output logic        m_tag,
  input  logic        m_rvld,
  input  logic        m_rtag,
  input  logic [31:0] m_sum0,
  input  logic [31:0] m_sum1,
  output logic        r0_vld,
  input  logic        r0_rdy,
  output logic [31:0] r0_prod,
  output logic        r1_vld,
  input  logic        r1_rdy,
  output logic [31:0] r1_prod,
  output logic        busy,
  output logic        err
);
  localparam int CW = $clog2(FDEPTH + 1);

  // LAT is informational: result timing is owned by the multiplier.
  if (FDEPTH < 2 || (FDEPTH & (FDEPTH - 1)) != 0 || LAT < 0) begin : g_param_chk
    $error("mul_arbiter: FDEPTH must be a power of 2 and at least 2");
  end

  logic [CW-1:0] cred0, cred1;
  logic          ptr;
  logic          elig0, elig1, win0, win1;
  logic          pop0, pop1, empty0, empty1, full0, full1, drop0, drop1;
  logic [31:0]   sum;

  assign elig0 = s0_vld && (cred0 != '0);
  assign elig1 = s1_vld && (cred1 != '0);
  assign win0  = elig0 && (!elig1 || !ptr);
  assign win1  = elig1 && (!elig0 || ptr);
  assign s0_rdy = win0;
  assign s1_rdy = win1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0;
      m_a   <= '0;
      m_b   <= '0;
      m_tag <= 1'b0;
      ptr   <= 1'b0;
    end else begin
      m_vld <= win0 || win1;
      if (win0 || win1) begin
        m_a   <= win1 ? s1_a : s0_a;
        m_b   <= win1 ? s1_b : s0_b;
        m_tag <= win1;
        ptr   <= win0;
      end
    end
  end

  assign pop0 = r0_vld && r0_rdy;
  assign pop1 = r1_vld && r1_rdy;

  // A credit is held from issue until the response leaves its FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cred0 <= CW'(FDEPTH);
      cred1 <= CW'(FDEPTH);
    end else begin
      case ({win0, pop0})
        2'b10:   cred0 <= cred0 - 1'b1;
        2'b01:   cred0 <= cred0 + 1'b1;
        default: cred0 <= cred0;
      endcase
      case ({win1, pop1})
        2'b10:   cred1 <= cred1 - 1'b1;
        2'b01:   cred1 <= cred1 + 1'b1;
        default: cred1 <= cred1;
      endcase
    end
  end

  assign sum = m_sum0 + m_sum1;

  mul_arbiter_fifo #(.DEPTH(FDEPTH), .W(32)) u_fifo0 (
    .clk(clk), .rst_n(rst_n),
    .push(m_rvld && !m_rtag), .push_dat(sum), .pop(pop0),
    .empty(empty0), .full(full0), .drop(drop0), .head(r0_prod)
  );

  mul_arbiter_fifo #(.DEPTH(FDEPTH), .W(32)) u_fifo1 (
    .clk(clk), .rst_n(rst_n),
    .push(m_rvld && m_rtag), .push_dat(sum), .pop(pop1),
    .empty(empty1), .full(full1), .drop(drop1), .head(r1_prod)
  );

  assign r0_vld = !empty0;
  assign r1_vld = !empty1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err || drop0 || drop1;
  end

  assign busy = (cred0 != CW'(FDEPTH)) || (cred1 != CW'(FDEPTH)) || m_vld;
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: the multiplier side is driven by hand with known carry-save pairs.
module tb_mul_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_vld, s1_vld, s0_rdy, s1_rdy;
  logic [15:0] s0_a, s0_b, s1_a, s1_b;
  logic        m_vld, m_tag, m_rvld, m_rtag;
  logic [15:0] m_a, m_b;
  logic [31:0] m_sum0, m_sum1;
  logic        r0_vld, r0_rdy, r1_vld, r1_rdy;
  logic [31:0] r0_prod, r1_prod;
  logic        busy, err;

  int checks = 0;
  int errors = 0;
  int grants;

  mul_arbiter #(.LAT(3), .FDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_vld(s0_vld), .s0_rdy(s0_rdy), .s0_a(s0_a), .s0_b(s0_b),
    .s1_vld(s1_vld), .s1_rdy(s1_rdy), .s1_a(s1_a), .s1_b(s1_b),
    .m_vld(m_vld), .m_a(m_a), .m_b(m_b), .m_tag(m_tag),
    .m_rvld(m_rvld), .m_rtag(m_rtag), .m_sum0(m_sum0), .m_sum1(m_sum1),
    .r0_vld(r0_vld), .r0_rdy(r0_rdy), .r0_prod(r0_prod),
    .r1_vld(r1_vld), .r1_rdy(r1_rdy), .r1_prod(r1_prod),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    s0_vld = 1'b0; s1_vld = 1'b0;
    m_rvld = 1'b0; r0_rdy = 1'b0; r1_rdy = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic push_res(input logic tag, input logic [31:0] v0, input logic [31:0] v1);
    m_rvld = 1'b1; m_rtag = tag; m_sum0 = v0; m_sum1 = v1;
    tick;
    m_rvld = 1'b0;
  endtask

  initial begin
    s0_a = '0; s0_b = '0; s1_a = '0; s1_b = '0;
    m_rtag = 1'b0; m_sum0 = '0; m_sum1 = '0;
    s0_vld = 1'b0; s1_vld = 1'b0; m_rvld = 1'b0; r0_rdy = 1'b0; r1_rdy = 1'b0;
    rst_n = 1'b0;
    tick; tick;
    check("rst_m_vld", m_vld, 0);
    check("rst_m_a", m_a, 0);
    check("rst_m_tag", m_tag, 0);
    check("rst_busy", busy, 0);
    check("rst_r0_vld", r0_vld, 0);
    check("rst_r1_vld", r1_vld, 0);
    check("rst_r0_prod", r0_prod, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    // Single op 3*5 returned as carry-save 0xA + 0x5
    s0_vld = 1'b1; s0_a = 16'd3; s0_b = 16'd5;
    #1;
    check("single_s0_rdy", s0_rdy, 1);
    check("single_s1_rdy", s1_rdy, 0);
    tick;
    s0_vld = 1'b0;
    check("single_m_vld", m_vld, 1);
    check("single_m_a", m_a, 32'd3);
    check("single_m_b", m_b, 32'd5);
    check("single_m_tag", m_tag, 0);
    check("single_busy", busy, 1);
    tick;
    check("single_m_vld_idle", m_vld, 0);
    check("single_m_a_hold", m_a, 32'd3);
    tick;
    push_res(1'b0, 32'h0000000A, 32'h00000005);
    check("single_r0_vld", r0_vld, 1);
    check("single_r0_prod", r0_prod, 32'h0000000F);
    check("single_busy_pend", busy, 1);
    r0_rdy = 1'b1;
    tick;
    r0_rdy = 1'b0;
    check("single_r0_popped", r0_vld, 0);
    check("single_cred_back", busy, 0);

    // Contention: grants alternate starting at requester 0
    do_reset;
    s0_vld = 1'b1; s1_vld = 1'b1; s0_a = 16'h0010; s1_a = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_s0_rdy", s0_rdy, (i % 2 == 0) ? 1 : 0);
      check("cont_s1_rdy", s1_rdy, (i % 2 == 1) ? 1 : 0);
      tick;
      check("cont_m_tag", m_tag, i % 2);
      check("cont_m_a", m_a, (i % 2 == 0) ? 32'h10 : 32'h20);
    end
    s0_vld = 1'b0; s1_vld = 1'b0;

    // Backpressure: credits stop s0 after 4 issues
    do_reset;
    s0_vld = 1'b1; s0_a = 16'd7;
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      grants += int'(s0_rdy);
      tick;
    end
    check("bp_grants", grants, 4);
    #1;
    check("bp_s0_blocked", s0_rdy, 0);
    s1_vld = 1'b1;
    #1;
    check("bp_s1_rdy", s1_rdy, 1);
    tick;
    s1_vld = 1'b0;
    check("bp_s1_tag", m_tag, 1);
    for (int k = 0; k < 4; k++) push_res(1'b0, 32'd100 + k, 32'd0);
    check("bp_r0_head", r0_prod, 32'd100);
    r0_rdy = 1'b1;
    tick;
    r0_rdy = 1'b0;
    check("bp_r0_next", r0_prod, 32'd101);
    grants = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      grants += int'(s0_rdy);
      tick;
    end
    check("bp_one_more", grants, 1);
    s0_vld = 1'b0;

    // Wrap-around sum and negative product
    do_reset;
    s0_vld = 1'b1; s0_a = 16'd1; s0_b = 16'd1;
    tick;
    s0_vld = 1'b0;
    s1_vld = 1'b1; s1_a = 16'hFFFF; s1_b = 16'h0001;
    tick;
    s1_vld = 1'b0;
    check("sign_m_a", m_a, 32'h0000FFFF);
    check("sign_m_b", m_b, 32'h00000001);
    check("sign_m_tag", m_tag, 1);
    push_res(1'b0, 32'hFFFFFFFF, 32'h00000001);
    push_res(1'b1, 32'hFFFFFFFE, 32'h00000001);
    check("wrap_r0_vld", r0_vld, 1);
    check("wrap_r0_prod", r0_prod, 32'h00000000);
    check("sign_r1_prod", r1_prod, 32'hFFFFFFFF);
    check("wrap_err", err, 0);
    r0_rdy = 1'b1; r1_rdy = 1'b1;
    tick;
    r0_rdy = 1'b0; r1_rdy = 1'b0;
    check("wrap_busy", busy, 0);

    // Overflow of FIFO1 sets sticky err and keeps the first four
    do_reset;
    s1_vld = 1'b1;
    repeat (4) tick;
    s1_vld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push_res(1'b1, 32'd200 + k, 32'd0);
      if (k == 3) check("ovf_err_before", err, 0);
    end
    check("ovf_err_after", err, 1);
    for (int k = 0; k < 4; k++) begin
      check("ovf_r1_vld", r1_vld, 1);
      check("ovf_r1_order", r1_prod, 32'd200 + k);
      r1_rdy = 1'b1;
      tick;
      r1_rdy = 1'b0;
    end
    check("ovf_r1_drained", r1_vld, 0);
    check("ovf_err_sticky", err, 1);
    check("ovf_busy", busy, 0);

    // Reset mid-flight with 3 ops outstanding and a buffered result
    s0_vld = 1'b1; s1_vld = 1'b1; s0_a = 16'h0AAA; s1_a = 16'h0BBB; s0_b = 16'h0CCC;
    tick;
    m_rvld = 1'b1; m_rtag = 1'b0; m_sum0 = 32'd5; m_sum1 = 32'd0;
    tick;
    m_rvld = 1'b0;
    tick;
    s0_vld = 1'b0; s1_vld = 1'b0;
    check("mid_m_vld_pre", m_vld, 1);
    check("mid_r0_vld_pre", r0_vld, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_m_vld", m_vld, 0);
    check("mid_m_a", m_a, 0);
    check("mid_m_b", m_b, 0);
    check("mid_m_tag", m_tag, 0);
    check("mid_busy", busy, 0);
    check("mid_r0_vld", r0_vld, 0);
    check("mid_r1_vld", r1_vld, 0);
    check("mid_r0_prod", r0_prod, 0);
    check("mid_err", err, 0);
    tick;
    rst_n = 1'b1;
    s0_vld = 1'b1;
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      grants += int'(s0_rdy);
      tick;
    end
    s0_vld = 1'b0;
    check("mid_cred0_full", grants, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter LAT, default 3, SHALL be the fixed multiplier latency in cycles from m_vld to the matching m_rvld; this block only documents it and does not check it.
REQ-002 Parameter FDEPTH, default 4, SHALL set the per-requester response FIFO depth and credit count (power of 2, at least 2).
REQ-003 Ports SHALL be as listed, clock and reset first:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  asynchronous, active-low reset
 s0_vld / s1_vld  in  1  requester i operand valid
 s0_rdy / s1_rdy  out  1  requester i operand accepted
 s0_a, s0_b / s1_a, s1_b  in  16  requester i signed operands
 m_vld  out  1  issue to shared Booth/Dadda multiplier
 m_a, m_b  out  16  issued operands
 m_tag  out  1  issued requester id
 m_rvld  in  1  multiplier result valid
 m_rtag  in  1  result requester id
 m_sum0, m_sum1  in  32  carry-save outputs of the Dadda tree
 r0_vld / r1_vld  out  1  response i valid
 r0_rdy / r1_rdy  in  1  response i accepted
 r0_prod / r1_prod  out  32  response i product
 busy  out  1  any operation in flight or buffered
 err  out  1  sticky protocol-violation flag

Function
REQ-004 Credit counter cred_i (0..FDEPTH) SHALL gate requester i; elig_i = si_vld && (cred_i > 0).
REQ-005 Round-robin pointer ptr SHALL select the winner: if both are eligible, ptr wins; otherwise the single eligible requester wins.
REQ-006 si_rdy SHALL be combinational: high iff requester i is the winner this cycle; si_rdy never asserts when cred_i = 0.
REQ-007 Handshake si_vld && si_rdy SHALL register m_vld=1, m_a=si_a, m_b=si_b, m_tag=i on the next edge.
REQ-008 With no grant, m_vld SHALL be 0 next cycle; m_a, m_b and m_tag hold their values.
REQ-009 At most one grant per cycle SHALL occur, giving sustained throughput of 1 issue per cycle.
REQ-010 After a grant to i, ptr SHALL become 1-i; with no grant, ptr holds.
REQ-011 cred_i SHALL decrement on grant to i and increment on ri_vld && ri_rdy; when both occur in the same cycle it is unchanged.
REQ-012 On m_rvld, the block SHALL compute m_sum0 + m_sum1 modulo 2^32 (carry-out discarded) and push it into FIFO[m_rtag] on the same edge.
REQ-013 ri_vld SHALL equal "FIFO i not empty"; ri_prod SHALL be the FIFO head, driven from registers or RAM with no combinational path from m_sum*.
REQ-014 Pop SHALL occur on ri_vld && ri_rdy; simultaneous push and pop on a full FIFO SHALL be allowed (count unchanged, order preserved).
REQ-015 Responses SHALL emerge per requester in issue order; no ordering is imposed between requesters.
REQ-016 A push to a full FIFO SHALL drop the data and set err=1 until reset; all other state continues normally.
REQ-017 busy SHALL be high iff any cred_i < FDEPTH, or m_vld=1.
REQ-018 Pointers SHALL wrap modulo FDEPTH; FIFO count range is 0..FDEPTH.

Reset
REQ-019 rst_n low SHALL immediately clear m_vld, m_a, m_b, m_tag, ptr, FIFO pointers and counts, err, busy, ri_vld and ri_prod to 0, and set cred_i = FDEPTH.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight and buffered results; an m_rvld arriving after deassertion is treated per REQ-016.
REQ-021 Deassertion SHALL be synchronized externally; the first grant is possible in the first cycle after rst_n rises.

Verification
REQ-022 Single op: s0 issues a=3, b=5; model returns m_sum0=0x0000000A, m_sum1=0x00000005 after LAT -> r0_vld, r0_prod=0x0000000F, cred0 restored to 4 after pop.
REQ-023 Contention: s0_vld and s1_vld both held high for 4 cycles after reset -> grants in order 0,1,0,1; m_tag sequence 0,1,0,1.
REQ-024 Backpressure: r0_rdy=0 while s0 streams -> exactly 4 grants, then s0_rdy=0; s1 keeps getting grants; raising r0_rdy for 1 cycle allows exactly 1 more s0 grant.
REQ-025 Wrap and sign: m_sum0=0xFFFFFFFF, m_sum1=0x00000001 -> prod=0x00000000; a=-1, b=1 with m_sum0=0xFFFFFFFE, m_sum1=0x00000001 -> prod=0xFFFFFFFF.
REQ-026 Violation: force m_rvld with m_rtag=1 five times while r1_rdy=0 -> err=1 after the 5th; FIFO1 holds the first 4 values in order.
REQ-027 Reset mid-flight: rst_n pulled low with 3 outstanding ops -> all outputs at reset values immediately, cred0=cred1=4, r0_vld=r1_vld=0.
